// File: rtl/darkmm_pkg.sv
// Shared types and default memory map for the darkriscv data-port router.
package darkmm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Default map: ROM at 0, flash at 512 MiB, eDRAM/peripherals at 1 GiB.
    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] ROM_MASK   = 32'h1FFF_FFFF;
    localparam logic [31:0] FLASH_BASE = 32'h2000_0000;
    localparam logic [31:0] FLASH_MASK = 32'h1FFF_FFFF;
    localparam logic [31:0] EDRAM_BASE = 32'h4000_0000;
    localparam logic [31:0] EDRAM_MASK = 32'h3FFF_FFFF;

endpackage

// File: rtl/darkmm_region_match.sv
// Combinational base/mask address decoder; the lowest matching region index wins.
module darkmm_region_match #(
    parameter int unsigned         NREG = 3,
    parameter int unsigned         AW   = 32,
    parameter int unsigned         IW   = 2,
    parameter logic [NREG*AW-1:0]  BASE = '0,
    parameter logic [NREG*AW-1:0]  MASK = '0
) (
    input  logic [AW-1:0] addr_i,
    output logic          hit_o,
    output logic [IW-1:0] idx_o,
    output logic [AW-1:0] off_o
);

    // Scan high to low so the lowest hitting index is written last.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        off_o = '0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if ((addr_i & ~MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & ~MASK[i*AW +: AW])) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
                off_o = addr_i & MASK[i*AW +: AW];
            end
        end
    end

endmodule

// File: rtl/darkmm_router.sv
// Registered memory-map router: one master request is decoded, forwarded to one
// target with a region-relative offset, and completed by a one-cycle ack or bus error.
module darkmm_router
    import darkmm_pkg::*;
#(
    parameter int unsigned        NREG        = 3,
    parameter int unsigned        AW          = 32,
    parameter int unsigned        DW          = 32,
    parameter logic [NREG*AW-1:0] REGION_BASE = {EDRAM_BASE, FLASH_BASE, ROM_BASE},
    parameter logic [NREG*AW-1:0] REGION_MASK = {EDRAM_MASK, FLASH_MASK, ROM_MASK},
    parameter int unsigned        TIMEOUT     = 256,
    parameter logic [DW-1:0]      ERR_DATA    = DW'(ERR_DATA_DEFAULT)
) (
    input  logic               XCLK,
    input  logic               XRES,
    input  logic               req_i,
    input  logic               rd_i,
    input  logic               wr_i,
    input  logic [DW/8-1:0]    be_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [DW-1:0]      wdata_i,
    output logic [DW-1:0]      rdata_o,
    output logic               ack_o,
    output logic               err_o,
    output logic [NREG-1:0]    tgt_req_o,
    output logic               tgt_rd_o,
    output logic               tgt_wr_o,
    output logic [DW/8-1:0]    tgt_be_o,
    output logic [AW-1:0]      tgt_addr_o,
    output logic [DW-1:0]      tgt_wdata_o,
    input  logic [NREG*DW-1:0] tgt_rdata_i,
    input  logic [NREG-1:0]    tgt_ack_i
);

    localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned BW = DW / 8;

    logic          hit_c;
    logic [IW-1:0] idx_c;
    logic [AW-1:0] off_c;

    darkmm_region_match #(
        .NREG (NREG),
        .AW   (AW),
        .IW   (IW),
        .BASE (REGION_BASE),
        .MASK (REGION_MASK)
    ) u_match (
        .addr_i (addr_i),
        .hit_o  (hit_c),
        .idx_o  (idx_c),
        .off_o  (off_c)
    );

    state_e          state_q;
    logic [IW-1:0]   sel_q;
    logic [CW-1:0]   cnt_q;
    logic [NREG-1:0] tgt_req_q;
    logic            tgt_rd_q;
    logic            tgt_wr_q;
    logic [BW-1:0]   tgt_be_q;
    logic [AW-1:0]   tgt_addr_q;
    logic [DW-1:0]   tgt_wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            ack_q;
    logic            err_q;

    logic            sel_ack_c;
    logic [DW-1:0]   sel_rdata_c;

    // Only the selected target's ack and data are visible to the FSM.
    always_comb begin
        sel_ack_c   = 1'b0;
        sel_rdata_c = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (sel_q == IW'(i)) begin
                sel_ack_c   = tgt_ack_i[i];
                sel_rdata_c = tgt_rdata_i[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            tgt_req_q   <= '0;
            tgt_rd_q    <= 1'b0;
            tgt_wr_q    <= 1'b0;
            tgt_be_q    <= '0;
            tgt_addr_q  <= '0;
            tgt_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        tgt_rd_q    <= rd_i;
                        tgt_wr_q    <= wr_i;
                        tgt_be_q    <= be_i;
                        tgt_wdata_q <= wdata_i;
                        tgt_addr_q  <= off_c;
                        sel_q       <= idx_c;
                        cnt_q       <= '0;
                        if (hit_c && (rd_i ^ wr_i)) begin
                            state_q   <= BUSY;
                            tgt_req_q <= NREG'(1) << idx_c;
                            err_q     <= 1'b0;
                        end else begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= rd_i ? ERR_DATA : '0;
                        end
                    end
                end
                BUSY: begin
                    // A target ack in the final wait cycle takes precedence over the timeout.
                    if (sel_ack_c) begin
                        state_q   <= RESP;
                        tgt_req_q <= '0;
                        ack_q     <= 1'b1;
                        err_q     <= 1'b0;
                        rdata_q   <= tgt_rd_q ? sel_rdata_c : '0;
                    end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
                        state_q   <= RESP;
                        tgt_req_q <= '0;
                        ack_q     <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= tgt_rd_q ? ERR_DATA : '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata_o     = rdata_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign tgt_req_o   = tgt_req_q;
    assign tgt_rd_o    = tgt_rd_q;
    assign tgt_wr_o    = tgt_wr_q;
    assign tgt_be_o    = tgt_be_q;
    assign tgt_addr_o  = tgt_addr_q;
    assign tgt_wdata_o = tgt_wdata_q;

endmodule
